// File: rtl/canny_frame_ctrl.sv
// canny_frame_ctrl
//   Frame sequencer for the Canny edge pipeline. Accepts a raster pixel
//   stream, drives the pipeline's shared input/advance, flushes the pipeline
//   at end of frame and emits pipeline results tagged with sof/eol/eof.
//
// Parameters
//   IMG_W, IMG_H : frame geometry in pixels / lines
//   PIPE_LAT     : pipeline advances from pipe_pixel to matching pipe_data
//   BORDER       : invalid border width (used only with the mask option)
//
// Ports
//   clk, rst            : clock (rising edge), async active-high reset
//   start               : begin a frame (sampled only while idle)
//   in_valid/in_ready   : source handshake, in_pixel is the source pixel
//   pipe_en/pipe_pixel  : pipeline advance and pipeline input
//   pipe_data           : pipeline (edge-linking) output
//   out_valid/out_ready : sink handshake for out_data/out_sof/out_eol/out_eof
//   busy                : frame in progress
//   frame_done          : one-cycle pulse after the last output handshake
//
// Build option
//   CANNY_BORDER_MASK_EN : force out_data to zero inside the BORDER-wide frame
//                          border (markers unaffected)
module canny_frame_ctrl #(
    parameter int unsigned IMG_W    = 512,
    parameter int unsigned IMG_H    = 512,
    parameter int unsigned PIPE_LAT = 2056,
    parameter int unsigned BORDER   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    output logic        pipe_en,
    output logic [7:0]  pipe_pixel,
    input  logic [11:0] pipe_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        busy,
    output logic        frame_done
);
    localparam int unsigned NPIX    = IMG_W * IMG_H;
    // in_cnt counts input pixels in RUN, then flush advances in FLUSH
    localparam int unsigned CNT_MAX = (NPIX > PIPE_LAT) ? NPIX : PIPE_LAT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned XW      = $clog2(IMG_W);
    localparam int unsigned YW      = $clog2(IMG_H);
    localparam int unsigned SW      = $clog2(PIPE_LAT + 1);

    localparam logic [CW-1:0] IN_LAST   = CW'(NPIX - 1);
    localparam logic [CW-1:0] FL_LAST   = CW'(PIPE_LAT - 1);
    localparam logic [SW-1:0] STEP_FULL = SW'(PIPE_LAT);
    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

    if (2 * BORDER > IMG_W || 2 * BORDER > IMG_H || PIPE_LAT == 0) begin : g_bad_cfg
        $error("canny_frame_ctrl: unsupported parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic          out_valid_q, out_valid_d;
    logic [11:0]   out_data_q, out_data_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eol_q, out_eol_d;
    logic          out_eof_q, out_eof_d;
    logic          frame_done_q, frame_done_d;
    logic          stall;
    logic          adv;
    logic [11:0]   load_data;

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        step_d       = step_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;
        pipe_pixel   = '0;
        adv          = 1'b0;
        load_data    = pipe_data;
        stall        = out_valid_q && !out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    in_cnt_d = '0;
                    step_d   = '0;
                    out_x_d  = '0;
                    out_y_d  = '0;
                end
            end
            S_RUN: begin
                in_ready   = !stall;
                adv        = in_valid && !stall;
                pipe_pixel = in_pixel;
                if (adv) begin
                    if (in_cnt_q == IN_LAST) begin
                        state_d  = S_FLUSH;
                        in_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                adv = !stall;
                if (adv) begin
                    if (in_cnt_q == FL_LAST) begin
                        state_d  = S_DRAIN;
                        in_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_eof_q) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A load may coincide with a handshake and replaces the register;
        // adv already excludes stall, so no unaccepted pixel is overwritten.
        if (adv) begin
            if (step_q != STEP_FULL) begin
                step_d = step_q + SW'(1);
            end else begin
`ifdef CANNY_BORDER_MASK_EN
                if (out_x_q < XW'(BORDER) || out_x_q >= XW'(IMG_W - BORDER) ||
                    out_y_q < YW'(BORDER) || out_y_q >= YW'(IMG_H - BORDER)) begin
                    load_data = '0;
                end
`endif
                out_valid_d = 1'b1;
                out_data_d  = load_data;
                out_sof_d   = (out_x_q == '0) && (out_y_q == '0);
                out_eol_d   = (out_x_q == X_LAST);
                out_eof_d   = (out_x_q == X_LAST) && (out_y_q == Y_LAST);
                if (out_x_q == X_LAST) begin
                    out_x_d = '0;
                    out_y_d = (out_y_q == Y_LAST) ? '0 : out_y_q + YW'(1);
                end else begin
                    out_x_d = out_x_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            step_q       <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            step_q       <= step_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pipe_en    = adv;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Bench for canny_frame_ctrl with an 8x6 frame, 4-advance stub pipeline and
// 1-pixel border. Outputs are checked against a frame-level model: output n
// is input pixel n (masked at the border when CANNY_BORDER_MASK_EN is set).
module tb_canny_frame_ctrl;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int LAT = 4;
    localparam int BRD = 1;
    localparam int N   = W * H;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = 8'h00;
    logic        pipe_en;
    logic [7:0]  pipe_pixel;
    logic [11:0] pipe_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        out_sof, out_eol, out_eof, busy, frame_done;

    canny_frame_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT), .BORDER(BRD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .pipe_en(pipe_en), .pipe_pixel(pipe_pixel), .pipe_data(pipe_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // stub pipeline: LAT-stage delay advancing on pipe_en
    logic [7:0] stub [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stub[i] <= 8'h00;
        end else if (pipe_en) begin
            stub[0] <= pipe_pixel;
            for (int i = 1; i < LAT; i++) stub[i] <= stub[i-1];
        end
    end
    assign pipe_data = {4'h0, stub[LAT-1]};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_val(input int idx, input logic [7:0] p);
        int x, y;
        x = idx % W;
        y = idx / W;
`ifdef CANNY_BORDER_MASK_EN
        if (x < BRD || x >= W - BRD || y < BRD || y >= H - BRD) return 12'h000;
`else
        if (x < 0 || y < 0) return 12'h000;
`endif
        return {4'h0, p};
    endfunction

    // model state
    logic [7:0]  pix [N];
    logic [11:0] got [N];
    logic [11:0] q [$];
    int phase = P_IDLE;
    int acc = 0, nfl = 0, nout = 0, en_cnt = 0;
    bit done_exp = 0, prev_stall = 0;
    logic [11:0] prev_data = '0;
    int unsigned valid_pct = 100, ready_pct = 100;
    int stall_left = 0;

    always @(negedge clk) begin
        bit st, exp_adv;
        logic [11:0] e;
        if (rst) begin
            phase = P_IDLE; acc = 0; nfl = 0; nout = 0; en_cnt = 0;
            q.delete(); done_exp = 0; prev_stall = 0;
        end else begin
            st = out_valid && !out_ready;
            exp_adv = 0;
            chk("busy", busy, phase != P_IDLE);
            chk("frame_done", frame_done, done_exp);
            done_exp = 0;
            case (phase)
                P_RUN: begin
                    exp_adv = in_valid && !st;
                    chk("run_in_ready", in_ready, !st);
                    chk("run_pipe_en", pipe_en, exp_adv);
                    if (exp_adv) chk("run_pipe_pixel", pipe_pixel, in_pixel);
                end
                P_FLUSH: begin
                    exp_adv = !st;
                    chk("flush_in_ready", in_ready, 0);
                    chk("flush_pipe_en", pipe_en, exp_adv);
                    chk("flush_pipe_pixel", pipe_pixel, 0);
                end
                default: begin
                    chk("idle_in_ready", in_ready, 0);
                    chk("idle_pipe_en", pipe_en, 0);
                end
            endcase
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", nout, 99);
                end else begin
                    e = q.pop_front();
                    if (nout < N) got[nout] = out_data;
                    chk("out_data", out_data, e);
                    chk("out_sof", out_sof, nout == 0);
                    chk("out_eol", out_eol, (nout % W) == W - 1);
                    chk("out_eof", out_eof, nout == N - 1);
                    nout++;
                end
            end
            if (exp_adv) en_cnt++;
            prev_stall = st;
            prev_data  = out_data;
            case (phase)
                P_IDLE: if (start) begin
                    phase = P_RUN; acc = 0; nfl = 0; nout = 0; en_cnt = 0;
                end
                P_RUN: if (exp_adv) begin
                    q.push_back(exp_val(acc, in_pixel));
                    acc++;
                    if (acc == N) phase = P_FLUSH;
                end
                P_FLUSH: if (exp_adv) begin
                    nfl++;
                    if (nfl == LAT) phase = P_DRAIN;
                end
                default: if (out_valid && out_ready && nout == N) begin
                    phase = P_IDLE;
                    done_exp = 1;
                    chk("out_count", nout, N);
                    chk("pipe_en_total", en_cnt, N + LAT);
                end
            endcase
        end
    end

    // source/sink driver
    always @(posedge clk) begin
        #1;
        in_valid = ($urandom_range(99) < valid_pct);
        in_pixel = (acc < N) ? pix[acc] : 8'h00;
        if (stall_left > 0 && phase == P_RUN && nout >= 20) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_pipe_pixel"}, pipe_pixel, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_sof"}, out_sof, 0);
        chk({tag, "_eol"}, out_eol, 0);
        chk({tag, "_eof"}, out_eof, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic run_frame(input int limit, input int pulse_at,
                             output int first_v, output int done_at);
        first_v = -1;
        done_at = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            start = (c == pulse_at);
            if (out_valid && first_v < 0) first_v = c;
            if (frame_done) begin
                done_at = c;
                break;
            end
        end
        start = 1'b0;
        if (done_at < 0) chk("frame_timeout", 0, 1);
    endtask

    task automatic lit_checks(input string tag);
        chk({tag, "_lit_out9"}, got[9], 9);
        chk({tag, "_lit_out10"}, got[10], 10);
`ifdef CANNY_BORDER_MASK_EN
        chk({tag, "_lit_out47"}, got[47], 0);
        chk({tag, "_lit_out8"}, got[8], 0);
`else
        chk({tag, "_lit_out47"}, got[47], 47);
        chk({tag, "_lit_out8"}, got[8], 8);
`endif
    endtask

    initial begin
        int fv, fd;
        for (int i = 0; i < N; i++) pix[i] = 8'(i);
        #2 rst = 1'b1;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // streaming frame
        run_frame(300, 0, fv, fd);
        chk("stream_first_valid", fv, LAT + 1);
        chk("stream_frame_done", fd, N + LAT + 1);
        lit_checks("stream");

        // 10-cycle sink stall mid-frame
        stall_left = 10;
        run_frame(400, 0, fv, fd);
        chk("stall_window_used", stall_left, 0);
        chk("stall_frame_done", fd, N + LAT + 1 + 10);
        lit_checks("stall");

        // random traffic, start pulsed during RUN, then a second frame
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        valid_pct = 50;
        ready_pct = 75;
        run_frame(3000, 15, fv, fd);
        run_frame(3000, 0, fv, fd);

        // reset after 20 inputs, then a clean frame
        for (int i = 0; i < N; i++) pix[i] = 8'(i);
        valid_pct = 100;
        ready_pct = 100;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 200 && acc < 20; c++) begin
            @(posedge clk); #1;
        end
        chk("reach_20_inputs", acc >= 20, 1);
        rst = 1'b1;
        #1 check_reset("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_frame(300, 0, fv, fd);
        chk("after_rst_first_valid", fv, LAT + 1);
        chk("after_rst_frame_done", fd, N + LAT + 1);
        lit_checks("after_rst");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
